// File: rtl/seq_magnitude_comparator.sv
// Sequential magnitude comparator.
// Compares two WIDTH-bit operands CHUNK bits per cycle, most-significant slice
// first. It stops at the first slice that differs and reports one-hot
// Lesser/Greater/Equal flags together with a single-cycle done pulse.
module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             Lesser,
    output logic             Greater,
    output logic             Equal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Keep the slice index at least one bit wide so NCHUNK == 1 still elaborates.
    localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic             signedMode_q;
    logic [IDXW-1:0]  idx_q;
    logic             busy_q;
    logic             done_q;
    logic             lesser_q;
    logic             greater_q;
    logic             equal_q;

    logic [CHUNK-1:0] msbMask;
    logic [CHUNK-1:0] sliceA;
    logic [CHUNK-1:0] sliceB;
    logic             sliceLt;
    logic             sliceGt;

    // Compare the current top slice. Inverting the MSB of the first slice in
    // signed mode turns the two's-complement order into a plain unsigned order.
    always_comb begin
        msbMask            = '0;
        msbMask[CHUNK-1]   = 1'b1;
        sliceA             = opA_q[WIDTH-1 -: CHUNK];
        sliceB             = opB_q[WIDTH-1 -: CHUNK];
        if (signedMode_q && (idx_q == '0)) begin
            sliceA = sliceA ^ msbMask;
            sliceB = sliceB ^ msbMask;
        end
        sliceLt = (sliceA < sliceB);
        sliceGt = (sliceA > sliceB);
    end

    // Control FSM together with the operand shift registers and registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            opA_q        <= '0;
            opB_q        <= '0;
            signedMode_q <= 1'b0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            lesser_q     <= 1'b0;
            greater_q    <= 1'b0;
            equal_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opA_q        <= a;
                        opB_q        <= b;
                        signedMode_q <= signed_mode;
                        idx_q        <= '0;
                        lesser_q     <= 1'b0;
                        greater_q    <= 1'b0;
                        equal_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= COMPARE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                COMPARE: begin
                    if (sliceLt || sliceGt) begin
                        lesser_q  <= sliceLt;
                        greater_q <= sliceGt;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if (idx_q == LAST_IDX) begin
                        equal_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        opA_q <= opA_q << CHUNK;
                        opB_q <= opB_q << CHUNK;
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Lesser  = lesser_q;
    assign Greater = greater_q;
    assign Equal   = equal_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Testbench for seq_magnitude_comparator: a 32/8 instance for directed cases
// and three 16-bit instances (CHUNK 1, 4, 16) for a shared parameter sweep.
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic        signedMode = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic        lesser;
    logic        greater;
    logic        equal;

    logic        start16 = 1'b0;
    logic        signed16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [2:0]  busy16;
    logic [2:0]  done16;
    logic [2:0]  lt16;
    logic [2:0]  gt16;
    logic [2:0]  eq16;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;

    typedef struct {
        logic [2:0] flags;
        int         lat;
        int         startCycle;
        string      tag;
    } exp_t;

    exp_t expQ[$];
    exp_t sweepQ[$];

    seq_magnitude_comparator #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signedMode),
        .a(a), .b(b), .busy(busy), .done(done),
        .Lesser(lesser), .Greater(greater), .Equal(equal)
    );

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(1)) dutC1 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(signed16),
        .a(a16), .b(b16), .busy(busy16[0]), .done(done16[0]),
        .Lesser(lt16[0]), .Greater(gt16[0]), .Equal(eq16[0])
    );

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dutC4 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(signed16),
        .a(a16), .b(b16), .busy(busy16[1]), .done(done16[1]),
        .Lesser(lt16[1]), .Greater(gt16[1]), .Equal(eq16[1])
    );

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(16)) dutC16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(signed16),
        .a(a16), .b(b16), .busy(busy16[2]), .done(done16[2]),
        .Lesser(lt16[2]), .Greater(gt16[2]), .Equal(eq16[2])
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to measure latency from the accepting edge.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Reference order of two width-bit values, returned as {Lesser, Greater, Equal}.
    function automatic logic [2:0] refFlags(logic [31:0] av, logic [31:0] bv, int width, bit s);
        longint sa = longint'(av);
        longint sb = longint'(bv);
        if (s && sa[width-1]) sa = sa - (longint'(1) << width);
        if (s && sb[width-1]) sb = sb - (longint'(1) << width);
        if (sa < sb) return 3'b100;
        if (sa > sb) return 3'b010;
        return 3'b001;
    endfunction

    // Expected edges from acceptance to result: first differing slice + 1, or slice count.
    function automatic int refLatency(logic [31:0] av, logic [31:0] bv, int width, int chunk);
        longint a64  = longint'(av);
        longint b64  = longint'(bv);
        longint mask = (longint'(1) << chunk) - 1;
        int     n    = width / chunk;
        for (int i = 0; i < n; i++) begin
            int sh = width - (i + 1) * chunk;
            if (((a64 >> sh) & mask) != ((b64 >> sh) & mask)) return i + 1;
        end
        return n;
    endfunction

    task automatic checkValue(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one request at a falling edge; the next rising edge accepts it.
    task automatic applyStimulus(logic [31:0] av, logic [31:0] bv, bit s, string tag, bit expectDone);
        a          = av;
        b          = bv;
        signedMode = s;
        start      = 1'b1;
        if (expectDone) begin
            exp_t e;
            e.flags      = refFlags(av, bv, 32, s);
            e.lat        = refLatency(av, bv, 32, 8);
            e.startCycle = cycleCount + 1;
            e.tag        = tag;
            expQ.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        checkValue({tag, " busy after accept"}, 32'(busy), 1);
    endtask

    // Wait (bounded) for done, then pop the oldest expectation and compare.
    task automatic checkOutput(int skipped);
        exp_t e;
        int   busyCount = 0;
        bit   seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) busyCount++;
        end
        e = expQ.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s timeout: observed no done, expected done within 20 cycles", e.tag);
        end else begin
            checkValue({e.tag, " flags"}, 32'({lesser, greater, equal}), 32'(e.flags));
            checkValue({e.tag, " latency"}, 32'(cycleCount - e.startCycle), 32'(e.lat));
            checkValue({e.tag, " busy at done"}, 32'(busy), 0);
            checkValue({e.tag, " busy cycles"}, 32'(busyCount + skipped + 1), 32'(e.lat));
        end
    endtask

    // Start all three 16-bit instances together and check each one's result and latency.
    task automatic sweepStep(logic [15:0] av, logic [15:0] bv, bit s);
        int         chunks[3] = '{1, 4, 16};
        int         lat[3]    = '{0, 0, 0};
        logic [2:0] fl[3]     = '{3'b000, 3'b000, 3'b000};
        bit         seen[3]   = '{1'b0, 1'b0, 1'b0};
        int         c0;
        exp_t       e;
        a16      = av;
        b16      = bv;
        signed16 = s;
        start16  = 1'b1;
        c0       = cycleCount + 1;
        for (int k = 0; k < 3; k++) begin
            e.flags      = refFlags(32'(av), 32'(bv), 16, s);
            e.lat        = refLatency(32'(av), 32'(bv), 16, chunks[k]);
            e.startCycle = c0;
            e.tag        = $sformatf("sweep C%0d a=%h b=%h s=%0d", chunks[k], av, bv, s);
            sweepQ.push_back(e);
        end
        @(negedge clk);
        start16 = 1'b0;
        for (int n = 0; n < 18; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (done16[k] && !seen[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = cycleCount - c0;
                    fl[k]   = {lt16[k], gt16[k], eq16[k]};
                end
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            e = sweepQ.pop_front();
            if (!seen[k]) begin
                checks++;
                errors++;
                $error("[TB] FAIL %s timeout: observed no done, expected done", e.tag);
            end else begin
                checkValue({e.tag, " flags"}, 32'(fl[k]), 32'(e.flags));
                checkValue({e.tag, " latency"}, 32'(lat[k]), 32'(e.lat));
            end
        end
    endtask

    // Directed sequence followed by the parameter sweep.
    initial begin
        int doneCount;
        logic [15:0] ra;
        logic [15:0] rb;

        $display("[TB] reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkValue("reset outputs", 32'({busy, done, lesser, greater, equal}), 0);
        rst = 1'b0;
        @(negedge clk);
        checkValue("idle after reset", 32'({busy, done, lesser, greater, equal}), 0);

        $display("[TB] directed compares");
        applyStimulus(32'd2, 32'd2, 1'b0, "unsigned equal", 1'b1);
        checkOutput(0);
        @(negedge clk);
        checkValue("done single pulse", 32'({busy, done}), 0);
        checkValue("flags held", 32'({lesser, greater, equal}), 32'(3'b001));

        applyStimulus(32'd22, 32'd444, 1'b0, "early exit lesser", 1'b1);
        checkOutput(0);
        applyStimulus(32'd777, 32'd111, 1'b0, "back-to-back greater", 1'b1);
        checkOutput(0);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b1, "signed minus one", 1'b1);
        checkOutput(0);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, "unsigned max", 1'b1);
        checkOutput(0);
        applyStimulus(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, "signed last slice", 1'b1);
        checkOutput(0);
        @(negedge clk);

        $display("[TB] start while busy");
        applyStimulus(32'd8888, 32'd8888, 1'b0, "start ignored", 1'b1);
        a     = 32'd1;
        b     = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkValue("busy despite start", 32'(busy), 1);
        checkOutput(1);
        @(negedge clk);
        checkValue("one done after ignored start", 32'({busy, done}), 0);

        $display("[TB] reset mid-compare");
        applyStimulus(32'd8888, 32'd8888, 1'b0, "reset abort", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkValue("async reset clears", 32'({busy, done, lesser, greater, equal}), 0);
        @(negedge clk);
        rst = 1'b0;
        doneCount = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkValue("no done after reset", 32'(doneCount), 0);
        applyStimulus(32'd5, 32'd9, 1'b0, "after reset", 1'b1);
        checkOutput(0);

        $display("[TB] parameter sweep");
        sweepStep(16'h1234, 16'h1234, 1'b0);
        sweepStep(16'h8000, 16'h7FFF, 1'b1);
        sweepStep(16'h8000, 16'h7FFF, 1'b0);
        sweepStep(16'h0001, 16'h0000, 1'b1);
        sweepStep(16'hFFF0, 16'hFFF8, 1'b1);
        for (int r = 0; r < 12; r++) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rb = ra ^ 16'(1 << $urandom_range(0, 15));
            else if ($urandom_range(0, 3) == 0) rb = ra;
            else rb = 16'($urandom);
            sweepStep(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, clocked successor to the 32-bit combinational comparator.
- Compares two WIDTH-bit operands one CHUNK-bit slice per cycle, most-significant slice first, in signed or unsigned mode.
- Terminates early at the first differing slice and returns registered one-hot Lesser/Greater/Equal flags with a start/busy/done handshake.
- Sits beside datapath blocks that need area-cheap wide compares where multi-cycle latency is acceptable.

Parameters:
- WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK (derived localparam), number of slices.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE or DONE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in COMPARE.
- done  output  1  single-cycle pulse; result valid.
- Lesser  output  1  A < B.
- Greater  output  1  A > B.
- Equal  output  1  A == B.

Behaviour:
- Reset (async, active-high): state=IDLE; busy, done, Lesser, Greater and Equal all 0; operand shift registers and slice counter cleared.
- States are IDLE, COMPARE and DONE.
- IDLE/DONE + start=1 at edge E0:
  - latch a, b and signed_mode into internal registers;
  - clear Lesser/Greater/Equal;
  - slice index i=0;
  - go to COMPARE (busy=1 after E0).
- COMPARE, at each edge: compare the top slice i of the latched A and B.
  - Slice 0 in signed mode compares with each slice's MSB inverted, which is equivalent to sign-bit reversal. All other slices, and all slices in unsigned mode, compare unsigned.
  - If the slices differ: set exactly one of Lesser/Greater, go to DONE.
  - Else if i == NCHUNK-1: set Equal, go to DONE.
  - Else: shift both operands left by CHUNK, i=i+1, stay in COMPARE.
- Latency: with the first differing slice at index i, the result flags and done=1 are visible after edge E(i+1). For equal operands, they are visible after edge E(NCHUNK). No other cycle count is acceptable.
- DONE:
  - done=1 for exactly one cycle.
  - If start=1 in that cycle, the next request is accepted (back-to-back); otherwise go to IDLE.
- Flags are held from DONE until the next accepted start or reset. Exactly one flag is high whenever done has pulsed since the last start; all are 0 while busy.
- start while busy: ignored; latched operands are unaffected and no error is raised.
- a/b/signed_mode changing during COMPARE: no effect, because operands are latched.
- Reset mid-COMPARE: immediate abort to IDLE, all outputs 0, no done pulse.
- NCHUNK=1 (CHUNK=WIDTH): single-cycle compare; done follows every accepted start by one edge.

Test Plan:
- Unsigned equal: a=2, b=2, start → Equal=1, Lesser=Greater=0, done after E4 (WIDTH=32, CHUNK=8); busy high for 4 cycles.
- Unsigned early exit: a=22, b=444 → slice 2 differs (0x00 vs 0x01) → Lesser=1, done after E3. Then a=777, b=111 back-to-back in the DONE cycle → Greater=1, done 3 edges after acceptance.
- Signed vs unsigned: a=32'hFFFF_FFFF, b=1.
  - signed_mode=1 → Lesser=1, done after E1.
  - signed_mode=0 → Greater=1, done after E1.
- Start ignored while busy: a=8888, b=8888 start; at E1 pulse start with a=1, b=0 → still Equal=1 after E4, only one done pulse.
- Reset mid-operation: a=8888, b=8888 start; assert rst between E2 and E3 → busy, done and all flags 0 immediately (async); no done afterwards; a fresh start after rst release behaves normally.
- Parameter sweep: WIDTH=16 with CHUNK=1, 4 and 16, random signed/unsigned operands → flags match a reference compare; latency = first differing slice index + 1, or NCHUNK when equal.
